branch_target_predictor: RTL and testbench

Fully associative branch target buffer with 2-bit saturating direction counters. It answers the fetch stage's per-cycle lookup for the current 8-byte fetch block, producing the `OUT_BP_*` prediction bundle that the program counter consumes. It learns from resolved-branch updates issued by the branch unit at execute.

---
 rtl/branch_target_predictor.sv | 182 ++++++++++++++++++
 tb/tb_branch_target_predictor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Fully associative branch target buffer with 2-bit saturating direction counters.
// Latency: lookup is combinational (zero cycles); updates land on the next clk edge.
// Backpressure: none; one lookup and one resolved-branch update are accepted every cycle.
//
// Ports:
//   clk, rst                  clock and asynchronous active-low reset
//   IN_pcValid, IN_pc         fetch-block lookup request
//   OUT_BP_*                  prediction for the first branch at/after IN_pc in the 8-byte block
//   IN_BU_*                   resolved-branch update from the branch unit
module branch_target_predictor #(
    parameter int         NUM_ENTRIES = 8,
    parameter logic [1:0] CNT_INIT    = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_pcValid,
    input  logic [31:0] IN_pc,
    output logic        OUT_BP_branchFound,
    output logic        OUT_BP_branchTaken,
    output logic        OUT_BP_isJump,
    output logic [31:0] OUT_BP_branchSrc,
    output logic [31:0] OUT_BP_branchDst,
    output logic [5:0]  OUT_BP_branchID,
    output logic        OUT_BP_multipleBranches,
    input  logic        IN_BU_valid,
    input  logic [31:0] IN_BU_src,
    input  logic [31:0] IN_BU_dst,
    input  logic        IN_BU_isJump,
    input  logic        IN_BU_taken,
    input  logic [5:0]  IN_BU_branchID
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [NUM_ENTRIES-1:0] isjump_q, isjump_d;
    logic [31:1]            src_q [NUM_ENTRIES];
    logic [31:1]            src_d [NUM_ENTRIES];
    logic [31:1]            dst_q [NUM_ENTRIES];
    logic [31:1]            dst_d [NUM_ENTRIES];
    logic [1:0]             cnt_q [NUM_ENTRIES];
    logic [1:0]             cnt_d [NUM_ENTRIES];
    logic [IDX_W-1:0]       repl_q, repl_d;

    // Bit 0 of addresses never matters (2-byte instruction alignment); pc[1] is below block granularity.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IN_pc[1:0], IN_BU_src[0], IN_BU_dst[0]};

    // ---------------- lookup ----------------
    logic [NUM_ENTRIES-1:0] match;
    logic                   found_lo, found_hi, sel_found, sel_taken;
    logic [IDX_W-1:0]       idx_lo, idx_hi, sel_idx;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match[i] = IN_pcValid && valid_q[i] && (src_q[i][31:3] == IN_pc[31:3])
                       && (src_q[i][2] >= IN_pc[2]);
        end
    end

    // Matches are split by half-block; the lower half wins, and within a half the lowest
    // index wins (descending scan lets the last write be the lowest index).
    always_comb begin
        found_lo = 1'b0;
        found_hi = 1'b0;
        idx_lo   = '0;
        idx_hi   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match[i] && !src_q[i][2]) begin
                found_lo = 1'b1;
                idx_lo   = IDX_W'(i);
            end
            if (match[i] && src_q[i][2]) begin
                found_hi = 1'b1;
                idx_hi   = IDX_W'(i);
            end
        end
        sel_found = found_lo | found_hi;
        sel_idx   = found_lo ? idx_lo : idx_hi;
    end

    always_comb begin
        OUT_BP_branchFound = sel_found;
        OUT_BP_branchTaken = 1'b0;
        OUT_BP_isJump      = 1'b0;
        OUT_BP_branchSrc   = '0;
        OUT_BP_branchDst   = '0;
        OUT_BP_branchID    = 6'd63;
        sel_taken          = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_found && sel_idx == IDX_W'(i)) begin
                OUT_BP_branchTaken = cnt_q[i][1];
                OUT_BP_isJump      = isjump_q[i];
                OUT_BP_branchSrc   = {src_q[i], 1'b0};
                OUT_BP_branchDst   = {dst_q[i], 1'b0};
                OUT_BP_branchID    = 6'(i);
                sel_taken          = isjump_q[i] | cnt_q[i][1];
            end
        end
        // A second branch can only follow the first when the first sits in the lower half.
        OUT_BP_multipleBranches = found_lo && found_hi && !sel_taken;
    end

    // ---------------- update ----------------
    logic             id_hit, cam_hit, hit;
    logic [IDX_W-1:0] id_idx, cam_idx, hit_idx;

    always_comb begin
        id_hit  = 1'b0;
        id_idx  = '0;
        cam_hit = 1'b0;
        cam_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (IN_BU_branchID == 6'(i) && valid_q[i] && src_q[i] == IN_BU_src[31:1]) begin
                id_hit = 1'b1;
                id_idx = IDX_W'(i);
            end
            if (valid_q[i] && src_q[i] == IN_BU_src[31:1]) begin
                cam_hit = 1'b1;
                cam_idx = IDX_W'(i);
            end
        end
        hit     = id_hit | cam_hit;
        hit_idx = id_hit ? id_idx : cam_idx;
    end

    always_comb begin
        valid_d  = valid_q;
        isjump_d = isjump_q;
        src_d    = src_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        repl_d   = repl_q;
        if (IN_BU_valid) begin
            if (hit) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (hit_idx == IDX_W'(i)) begin
                        if (IN_BU_taken) begin
                            cnt_d[i]    = (cnt_q[i] == 2'b11) ? 2'b11 : cnt_q[i] + 2'b01;
                            dst_d[i]    = IN_BU_dst[31:1];
                            isjump_d[i] = IN_BU_isJump;
                        end else begin
                            cnt_d[i]    = (cnt_q[i] == 2'b00) ? 2'b00 : cnt_q[i] - 2'b01;
                        end
                    end
                end
            end else if (IN_BU_taken) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (repl_q == IDX_W'(i)) begin
                        valid_d[i]  = 1'b1;
                        src_d[i]    = IN_BU_src[31:1];
                        dst_d[i]    = IN_BU_dst[31:1];
                        isjump_d[i] = IN_BU_isJump;
                        cnt_d[i]    = CNT_INIT;
                    end
                end
                repl_d = (repl_q == IDX_W'(NUM_ENTRIES - 1)) ? '0 : repl_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            isjump_q <= '0;
            repl_q   <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                src_q[i] <= '0;
                dst_q[i] <= '0;
                cnt_q[i] <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            isjump_q <= isjump_d;
            repl_q   <= repl_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                src_q[i] <= src_d[i];
                dst_q[i] <= dst_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: expected predictions are queued when a
// lookup is driven and popped when the combinational outputs are sampled.
module tb_branch_target_predictor;
    localparam int NE = 8;

    typedef struct packed {
        logic        found;
        logic        taken;
        logic        jump;
        logic [31:0] src;
        logic [31:0] dst;
        logic [5:0]  id;
        logic        mult;
    } pred_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IN_pcValid = 1'b0;
    logic [31:0] IN_pc = '0;
    logic        OUT_BP_branchFound, OUT_BP_branchTaken, OUT_BP_isJump, OUT_BP_multipleBranches;
    logic [31:0] OUT_BP_branchSrc, OUT_BP_branchDst;
    logic [5:0]  OUT_BP_branchID;
    logic        IN_BU_valid = 1'b0;
    logic [31:0] IN_BU_src = '0;
    logic [31:0] IN_BU_dst = '0;
    logic        IN_BU_isJump = 1'b0;
    logic        IN_BU_taken = 1'b0;
    logic [5:0]  IN_BU_branchID = 6'd63;

    int    errors = 0;
    int    checks = 0;
    pred_t exp_q[$];
    pred_t got, exp_e;

    branch_target_predictor #(.NUM_ENTRIES(NE), .CNT_INIT(2'b10)) dut (
        .clk(clk), .rst(rst),
        .IN_pcValid(IN_pcValid), .IN_pc(IN_pc),
        .OUT_BP_branchFound(OUT_BP_branchFound), .OUT_BP_branchTaken(OUT_BP_branchTaken),
        .OUT_BP_isJump(OUT_BP_isJump), .OUT_BP_branchSrc(OUT_BP_branchSrc),
        .OUT_BP_branchDst(OUT_BP_branchDst), .OUT_BP_branchID(OUT_BP_branchID),
        .OUT_BP_multipleBranches(OUT_BP_multipleBranches),
        .IN_BU_valid(IN_BU_valid), .IN_BU_src(IN_BU_src), .IN_BU_dst(IN_BU_dst),
        .IN_BU_isJump(IN_BU_isJump), .IN_BU_taken(IN_BU_taken), .IN_BU_branchID(IN_BU_branchID)
    );

    always #5 clk = ~clk;

    function automatic pred_t mk(input logic f, input logic t, input logic j,
                                 input logic [31:0] s, input logic [31:0] d,
                                 input logic [5:0] id, input logic m);
        return '{f, t, j, s, d, id, m};
    endfunction

    function automatic pred_t obs();
        return '{OUT_BP_branchFound, OUT_BP_branchTaken, OUT_BP_isJump, OUT_BP_branchSrc,
                 OUT_BP_branchDst, OUT_BP_branchID, OUT_BP_multipleBranches};
    endfunction

    localparam pred_t NONE = '{1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'd63, 1'b0};

    task automatic do_reset();
        @(negedge clk);
        IN_BU_valid = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic bu(input logic [31:0] s, input logic [31:0] d, input logic j,
                      input logic t, input logic [5:0] id);
        @(negedge clk);
        IN_BU_valid = 1'b1; IN_BU_src = s; IN_BU_dst = d;
        IN_BU_isJump = j; IN_BU_taken = t; IN_BU_branchID = id;
        @(negedge clk);
        IN_BU_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        IN_pcValid = 1'b1;
        IN_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        exp_q.push_back(NONE); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL reset_state got=%h exp=%h", got, exp_e); end
        #1 rst = 1'b1;
        bu(32'h1004, 32'h2000, 1'b0, 1'b1, 6'd63);
        bu(32'h1100, 32'h3000, 1'b0, 1'b1, 6'd63);
        bu(32'h1200, 32'h4000, 1'b0, 1'b1, 6'd63);
        exp_q.push_back(mk(1, 1, 0, 32'h1100, 32'h3000, 6'd1, 0)); look(32'h1100);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL prereset_lookup got=%h exp=%h", got, exp_e); end
        // Assert reset mid-run with an update in flight across a clock edge.
        @(negedge clk);
        rst = 1'b0;
        IN_BU_valid = 1'b1; IN_BU_src = 32'h1300; IN_BU_dst = 32'h5000;
        IN_BU_isJump = 1'b0; IN_BU_taken = 1'b1; IN_BU_branchID = 6'd63;
        exp_q.push_back(NONE); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL reset_midrun got=%h exp=%h", got, exp_e); end
        IN_BU_valid = 1'b0;
        #1 rst = 1'b1;
        exp_q.push_back(NONE); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL after_release_1004 got=%h exp=%h", got, exp_e); end
        exp_q.push_back(NONE); look(32'h1100);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL after_release_1100 got=%h exp=%h", got, exp_e); end
        exp_q.push_back(NONE); look(32'h1300);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL inflight_discarded got=%h exp=%h", got, exp_e); end
        bu(32'h1300, 32'h5000, 1'b0, 1'b1, 6'd63);
        exp_q.push_back(mk(1, 1, 0, 32'h1300, 32'h5000, 6'd0, 0)); look(32'h1300);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL first_update_after_release got=%h exp=%h", got, exp_e); end
    endtask

    task automatic test_alloc_predict();
        do_reset();
        bu(32'h1004, 32'h2000, 1'b0, 1'b1, 6'd63);
        exp_q.push_back(mk(1, 1, 0, 32'h1004, 32'h2000, 6'd0, 0)); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL alloc_predict got=%h exp=%h", got, exp_e); end
        bu(32'h2010, 32'h5000, 1'b1, 1'b1, 6'd63);
        exp_q.push_back(mk(1, 1, 1, 32'h2010, 32'h5000, 6'd1, 0)); look(32'h2010);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL alloc_jump got=%h exp=%h", got, exp_e); end
        bu(32'h3000, 32'h6000, 1'b0, 1'b0, 6'd63);
        exp_q.push_back(NONE); look(32'h3000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL miss_not_taken_no_alloc got=%h exp=%h", got, exp_e); end
        exp_q.push_back(NONE);
        @(negedge clk); IN_pcValid = 1'b0; IN_pc = 32'h1000; #1;
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL pcvalid_low got=%h exp=%h", got, exp_e); end
    endtask

    task automatic test_block_offset();
        do_reset();
        bu(32'h1000, 32'h6000, 1'b0, 1'b1, 6'd63);
        exp_q.push_back(NONE); look(32'h1004);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL block_offset_after got=%h exp=%h", got, exp_e); end
        exp_q.push_back(mk(1, 1, 0, 32'h1000, 32'h6000, 6'd0, 0)); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL block_offset_at got=%h exp=%h", got, exp_e); end
    endtask

    task automatic test_counter_sat();
        // Each row: update ID, taken, dst written, expected predicted-taken afterwards, expected dst.
        logic [5:0]  ids [9] = '{6'd0, 6'd63, 6'd5, 6'd0, 6'd0, 6'd0, 6'd63, 6'd0, 6'd0};
        logic        tks [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] dsts[9] = '{32'h7770, 32'h7770, 32'h7770, 32'h2100, 32'h2100,
                                 32'h2100, 32'h2100, 32'h7770, 32'h7770};
        logic        ept [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] edst[9] = '{32'h2000, 32'h2000, 32'h2000, 32'h2100, 32'h2100,
                                 32'h2100, 32'h2100, 32'h2100, 32'h2100};
        do_reset();
        bu(32'h1000, 32'h2000, 1'b0, 1'b1, 6'd63);
        for (int k = 0; k < 9; k++) begin
            bu(32'h1000, dsts[k], 1'b0, tks[k], ids[k]);
            exp_q.push_back(mk(1, ept[k], 0, 32'h1000, edst[k], 6'd0, 0)); look(32'h1000);
            got = obs(); exp_e = exp_q.pop_front(); checks++;
            if (got !== exp_e) begin
                errors++; $display("FAIL counter_step%0d got=%h exp=%h", k, got, exp_e);
            end
        end
    endtask

    task automatic test_multiple();
        do_reset();
        bu(32'h1004, 32'h3000, 1'b0, 1'b1, 6'd63);
        bu(32'h1000, 32'h2000, 1'b0, 1'b1, 6'd63);
        exp_q.push_back(mk(1, 1, 0, 32'h1000, 32'h2000, 6'd1, 0)); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL lower_half_wins got=%h exp=%h", got, exp_e); end
        bu(32'h1000, 32'h2000, 1'b0, 1'b0, 6'd1);
        bu(32'h1000, 32'h2000, 1'b0, 1'b0, 6'd63);
        exp_q.push_back(mk(1, 0, 0, 32'h1000, 32'h2000, 6'd1, 1)); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL multiple_set got=%h exp=%h", got, exp_e); end
        exp_q.push_back(mk(1, 1, 0, 32'h1004, 32'h3000, 6'd0, 0)); look(32'h1004);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL upper_half_only got=%h exp=%h", got, exp_e); end
        bu(32'h1000, 32'h2000, 1'b0, 1'b1, 6'd1);
        exp_q.push_back(mk(1, 0, 0, 32'h1000, 32'h2000, 6'd1, 1)); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL multiple_after_one_taken got=%h exp=%h", got, exp_e); end
        bu(32'h1000, 32'h2000, 1'b0, 1'b1, 6'd1);
        exp_q.push_back(mk(1, 1, 0, 32'h1000, 32'h2000, 6'd1, 0)); look(32'h1000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL multiple_cleared got=%h exp=%h", got, exp_e); end
    endtask

    task automatic test_wraparound();
        do_reset();
        for (int k = 0; k < NE; k++) bu(32'h4000 + 32'(k) * 32'h10, 32'h8000 + 32'(k) * 32'h10, 1'b0, 1'b1, 6'd63);
        for (int k = 0; k < NE; k++) begin
            exp_q.push_back(mk(1, 1, 0, 32'h4000 + 32'(k) * 32'h10, 32'h8000 + 32'(k) * 32'h10, 6'(k), 0));
            look(32'h4000 + 32'(k) * 32'h10);
            got = obs(); exp_e = exp_q.pop_front(); checks++;
            if (got !== exp_e) begin errors++; $display("FAIL fill_entry%0d got=%h exp=%h", k, got, exp_e); end
        end
        // Overwrite entry 0 while looking it up in the same cycle.
        @(negedge clk);
        IN_BU_valid = 1'b1; IN_BU_src = 32'h5000; IN_BU_dst = 32'h9000;
        IN_BU_isJump = 1'b0; IN_BU_taken = 1'b1; IN_BU_branchID = 6'd63;
        IN_pcValid = 1'b1; IN_pc = 32'h4000;
        exp_q.push_back(mk(1, 1, 0, 32'h4000, 32'h8000, 6'd0, 0));
        #1;
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL overwrite_same_cycle got=%h exp=%h", got, exp_e); end
        @(negedge clk);
        IN_BU_valid = 1'b0;
        exp_q.push_back(NONE); look(32'h4000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL evicted_first got=%h exp=%h", got, exp_e); end
        exp_q.push_back(mk(1, 1, 0, 32'h5000, 32'h9000, 6'd0, 0)); look(32'h5000);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL wrap_to_entry0 got=%h exp=%h", got, exp_e); end
        bu(32'h5010, 32'h9010, 1'b0, 1'b1, 6'd63);
        exp_q.push_back(mk(1, 1, 0, 32'h5010, 32'h9010, 6'd1, 0)); look(32'h5010);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL wrap_next_entry1 got=%h exp=%h", got, exp_e); end
        exp_q.push_back(NONE); look(32'h4010);
        got = obs(); exp_e = exp_q.pop_front(); checks++;
        if (got !== exp_e) begin errors++; $display("FAIL evicted_second got=%h exp=%h", got, exp_e); end
    endtask

    initial begin
        test_reset();
        test_alloc_predict();
        test_block_offset();
        test_counter_sat();
        test_multiple();
        test_wraparound();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
